// File: rtl/plot_writer.sv
// rtl/plot_writer.sv - point sink: FIFO, clip, duplicate drop, framebuffer write and screen clear
module plot_writer #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int ADDR_W     = 15,
    parameter int COLOR_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [7:0]         X_IN,
    input  logic [7:0]         Y_IN,
    input  logic [COLOR_W-1:0] C_IN,
    input  logic               CLR_REQ,
    input  logic [COLOR_W-1:0] CLR_COLOR,
    output logic               MEM_WE,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    output logic [COLOR_W-1:0] MEM_WDATA,
    input  logic               MEM_GRANT,
    output logic [15:0]        CLIP_CNT,
    output logic               BUSY
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 16 + COLOR_W;
    localparam logic [ADDR_W-1:0] H_A       = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] V_A       = ADDR_W'(V_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    logic [1:0]         state;
    logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PW:0]        wptr, rptr;
    logic               full, empty, push, pop;
    logic               ready_en;
    logic [7:0]         x_r, y_r;
    logic [COLOR_W-1:0] c_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [7:0]         last_x, last_y;
    logic [COLOR_W-1:0] last_c;
    logic               last_valid;
    logic               clr_pending;
    logic [COLOR_W-1:0] clr_color;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [15:0]        clip_cnt;
    logic               clip, dup;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

    // ready_en holds IN_READY low for the first cycle after reset release.
    assign IN_READY = ready_en && !full;
    assign push     = IN_VALID && IN_READY;
    assign pop      = (state == S_IDLE) && !clr_pending && !empty;

    assign clip = (ADDR_W'(x_r) >= H_A) || (ADDR_W'(y_r) >= V_A);
    assign dup  = last_valid && (x_r == last_x) && (y_r == last_y) && (c_r == last_c);

    assign MEM_WE    = (state == S_WRITE) || (state == S_CLEAR);
    assign MEM_ADDR  = (state == S_CLEAR) ? clr_cnt : addr_r;
    assign MEM_WDATA = (state == S_CLEAR) ? clr_color : c_r;
    assign CLIP_CNT  = clip_cnt;
    assign BUSY      = !empty || (state != S_IDLE) || clr_pending;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state       <= S_IDLE;
            wptr        <= '0;
            rptr        <= '0;
            ready_en    <= 1'b0;
            x_r         <= '0;
            y_r         <= '0;
            c_r         <= '0;
            addr_r      <= '0;
            last_x      <= '0;
            last_y      <= '0;
            last_c      <= '0;
            last_valid  <= 1'b0;
            clr_pending <= 1'b0;
            clr_color   <= '0;
            clr_cnt     <= '0;
            clip_cnt    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                fifo_mem[wptr[PW-1:0]] <= {X_IN, Y_IN, C_IN};
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            // A request while a clear is pending or running is dropped, colour included.
            if (CLR_REQ && !clr_pending) begin
                clr_pending <= 1'b1;
                clr_color   <= CLR_COLOR;
            end

            case (state)
                S_IDLE: begin
                    if (clr_pending) begin
                        clr_cnt <= '0;
                        state   <= S_CLEAR;
                    end else if (!empty) begin
                        {x_r, y_r, c_r} <= fifo_mem[rptr[PW-1:0]];
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    addr_r <= ADDR_W'(y_r) * H_A + ADDR_W'(x_r);
                    if (clip) begin
                        if (clip_cnt != 16'hFFFF) begin
                            clip_cnt <= clip_cnt + 16'd1;
                        end
                        state <= S_IDLE;
                    end else if (dup) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (MEM_GRANT) begin
                        last_x     <= x_r;
                        last_y     <= y_r;
                        last_c     <= c_r;
                        last_valid <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    if (MEM_GRANT) begin
                        if (clr_cnt == LAST_ADDR) begin
                            clr_pending <= 1'b0;
                            last_valid  <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plot_writer.sv
// tb/tb_plot_writer.sv - scoreboard bench for plot_writer
module tb_plot_writer;

    logic        ACLK;
    logic        ARESETn;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  X_IN, Y_IN, C_IN;
    logic        CLR_REQ;
    logic [7:0]  CLR_COLOR;
    logic        MEM_WE;
    logic [14:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_GRANT;
    logic [15:0] CLIP_CNT;
    logic        BUSY;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    logic [22:0] exp_q[$];

    plot_writer dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .X_IN(X_IN), .Y_IN(Y_IN), .C_IN(C_IN),
        .CLR_REQ(CLR_REQ), .CLR_COLOR(CLR_COLOR),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_GRANT(MEM_GRANT), .CLIP_CNT(CLIP_CNT), .BUSY(BUSY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Every committed write is checked against the head of the expected queue.
    always @(negedge ACLK) begin
        if (MEM_WE === 1'b1 && MEM_GRANT === 1'b1) begin
            logic [22:0] e;
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0h (nothing expected)", MEM_ADDR, MEM_WDATA);
            end else begin
                e = exp_q.pop_front();
                if ({MEM_ADDR, MEM_WDATA} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%0h expected addr=%0d data=%0h",
                             MEM_ADDR, MEM_WDATA, e[22:8], e[7:0]);
                end
            end
        end
    end

    function automatic logic [22:0] pix(input int x, input int y, input logic [7:0] c);
        return {15'(y * 160 + x), c};
    endfunction

    task automatic push_pt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
        int n = 0;
        bit done = 0;
        X_IN = x; Y_IN = y; C_IN = c; IN_VALID = 1'b1;
        while (!done) begin
            @(negedge ACLK);
            if (IN_READY) done = 1;
            @(posedge ACLK); #1;
            n++;
            if (!done && n > 50) begin
                checks++; errors++;
                $display("FAIL push_timeout point=(%0d,%0d) IN_READY=%b expected 1", x, y, IN_READY);
                done = 1;
            end
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge ACLK);
        while (BUSY && n < limit) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout BUSY=%b expected 0", BUSY);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_reset;
        ARESETn = 1'b0;
        repeat (2) begin @(posedge ACLK); #1; end
        @(negedge ACLK);
        checks++; if (MEM_WE !== 1'b0)     begin errors++; $display("FAIL rst_we got %b expected 0", MEM_WE); end
        checks++; if (MEM_ADDR !== 15'd0)  begin errors++; $display("FAIL rst_addr got %0d expected 0", MEM_ADDR); end
        checks++; if (MEM_WDATA !== 8'd0)  begin errors++; $display("FAIL rst_wdata got %0h expected 0", MEM_WDATA); end
        checks++; if (CLIP_CNT !== 16'd0)  begin errors++; $display("FAIL rst_clip got %0d expected 0", CLIP_CNT); end
        checks++; if (BUSY !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b expected 0", BUSY); end
        checks++; if (IN_READY !== 1'b0)   begin errors++; $display("FAIL rst_ready got %b expected 0", IN_READY); end
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        checks++; if (IN_READY !== 1'b0)   begin errors++; $display("FAIL ready_early got %b expected 0", IN_READY); end
        @(posedge ACLK); #1;
        @(negedge ACLK);
        checks++; if (IN_READY !== 1'b1)   begin errors++; $display("FAIL ready_after_rst got %b expected 1", IN_READY); end
        @(posedge ACLK); #1;
    endtask

    task automatic test_latency;
        exp_q.push_back(pix(10, 20, 8'h3C));
        push_pt(8'd10, 8'd20, 8'h3C);
        IN_VALID = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge ACLK);
            checks++;
            if (MEM_WE !== (i == 3)) begin
                errors++;
                $display("FAIL latency_we cycle t+%0d got %b expected %b", i, MEM_WE, (i == 3));
            end
            if (i == 3) begin
                checks++;
                if (MEM_ADDR !== 15'd3210) begin
                    errors++;
                    $display("FAIL latency_addr got %0d expected 3210", MEM_ADDR);
                end
            end
            if (i == 4) begin
                checks++;
                if (BUSY !== 1'b0) begin errors++; $display("FAIL latency_busy got %b expected 0", BUSY); end
            end
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_clip;
        push_pt(8'd160, 8'd5, 8'h01);
        push_pt(8'd5, 8'd120, 8'h02);
        push_pt(8'd255, 8'd255, 8'h03);
        IN_VALID = 1'b0;
        wait_idle(100);
        checks++;
        if (CLIP_CNT !== 16'd3) begin errors++; $display("FAIL clip_cnt got %0d expected 3", CLIP_CNT); end
        exp_q.push_back(pix(159, 119, 8'h11));
        push_pt(8'd159, 8'd119, 8'h11);
        IN_VALID = 1'b0;
        wait_idle(100);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL clip_corner pending=%0d expected 0", exp_q.size()); end
    endtask

    task automatic test_dup;
        int w0 = wr_count;
        exp_q.push_back(pix(50, 60, 8'h07));
        exp_q.push_back(pix(50, 60, 8'h09));
        push_pt(8'd50, 8'd60, 8'h07);
        push_pt(8'd50, 8'd60, 8'h07);
        push_pt(8'd50, 8'd60, 8'h09);
        IN_VALID = 1'b0;
        wait_idle(100);
        checks++;
        if (wr_count - w0 != 2) begin errors++; $display("FAIL dup_writes got %0d expected 2", wr_count - w0); end
    endtask

    task automatic test_back_to_back;
        int acc = 0;
        bit hs;
        MEM_GRANT = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            X_IN = 8'(20 + acc); Y_IN = 8'd30; C_IN = 8'(acc); IN_VALID = 1'b1;
            @(negedge ACLK);
            hs = IN_READY;
            @(posedge ACLK);
            if (hs) begin
                exp_q.push_back(pix(20 + acc, 30, 8'(acc)));
                acc++;
            end
            #1;
        end
        IN_VALID = 1'b0;
        checks++;
        if (acc != 5) begin errors++; $display("FAIL bp_accepted got %0d expected 5", acc); end
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checks++;
            if (MEM_WE !== 1'b1 || MEM_ADDR !== 15'd4820 || IN_READY !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold we=%b addr=%0d ready=%b expected we=1 addr=4820 ready=0",
                         MEM_WE, MEM_ADDR, IN_READY);
            end
        end
        @(posedge ACLK); #1;
        MEM_GRANT = 1'b1;
        wait_idle(200);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain pending=%0d expected 0", exp_q.size()); end
    endtask

    task automatic test_clear;
        int w0 = wr_count;
        exp_q.push_back(pix(70, 80, 8'h55));
        for (int a = 0; a < 19200; a++) exp_q.push_back({15'(a), 8'h00});
        exp_q.push_back(pix(70, 80, 8'h55));
        exp_q.push_back(pix(71, 80, 8'h56));
        push_pt(8'd70, 8'd80, 8'h55);
        push_pt(8'd70, 8'd80, 8'h55);
        push_pt(8'd71, 8'd80, 8'h56);
        IN_VALID = 1'b0;
        CLR_COLOR = 8'h00; CLR_REQ = 1'b1;
        @(posedge ACLK); #1;
        CLR_REQ = 1'b0;
        wait_idle(25000);
        checks++;
        if (wr_count - w0 != 19203) begin errors++; $display("FAIL clear_writes got %0d expected 19203", wr_count - w0); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL clear_pending pending=%0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_clear;
        int n = 0;
        for (int a = 0; a < 19200; a++) exp_q.push_back({15'(a), 8'hA5});
        CLR_COLOR = 8'hA5; CLR_REQ = 1'b1;
        @(posedge ACLK); #1;
        CLR_REQ = 1'b0;
        push_pt(8'd90, 8'd90, 8'h77);
        IN_VALID = 1'b0;
        @(negedge ACLK);
        while (!(MEM_WE === 1'b1 && MEM_ADDR === 15'd500) && n < 2000) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (MEM_ADDR !== 15'd500) begin errors++; $display("FAIL reach_500 got addr=%0d expected 500", MEM_ADDR); end
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        checks++; if (MEM_WE !== 1'b0)    begin errors++; $display("FAIL abort_we got %b expected 0", MEM_WE); end
        checks++; if (CLIP_CNT !== 16'd0) begin errors++; $display("FAIL abort_clip got %0d expected 0", CLIP_CNT); end
        checks++; if (IN_READY !== 1'b0)  begin errors++; $display("FAIL abort_ready got %b expected 0", IN_READY); end
        checks++; if (BUSY !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b expected 0", BUSY); end
        exp_q.delete();
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        repeat (2) begin @(posedge ACLK); #1; end
        exp_q.push_back(pix(1, 2, 8'h33));
        push_pt(8'd1, 8'd2, 8'h33);
        IN_VALID = 1'b0;
        wait_idle(100);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL post_reset pending=%0d expected 0", exp_q.size()); end
    endtask

    initial begin
        ARESETn = 1'b0; IN_VALID = 1'b0; X_IN = '0; Y_IN = '0; C_IN = '0;
        CLR_REQ = 1'b0; CLR_COLOR = '0; MEM_GRANT = 1'b1;
        test_reset();
        test_latency();
        test_clip();
        test_dup();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        repeat (5) @(posedge ACLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
